sram_device_model: RTL



---
 rtl/sram_device_model_if.sv | 30 +++
 rtl/sram_device_model.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sram_device_model_if.sv
// SRAM pin-interface control/address bundle.
// Carries the word address and the active-low strobes that the memory-stage
// controller (master) drives toward the SRAM device (slave). The data bus
// SRAM_DQ is bidirectional and tri-stated, so it travels as a plain inout
// port beside this interface rather than inside it.
//   SRAM_ADDR  word address
//   SRAM_WE_N  write enable, active low
//   SRAM_OE_N  output enable, active low
//   SRAM_CE_N  chip enable, active low
//   SRAM_UB_N  upper byte lane [15:8] enable, active low
//   SRAM_LB_N  lower byte lane [7:0] enable, active low
// There is no valid/ready handshake on this bus: every clock edge samples
// one cycle type (idle, read or write) from CE_N/WE_N, and the device can
// never stall the controller.
interface sram_device_model_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  modport master (
    output SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface

// File: rtl/sram_device_model.sv
// Clocked model of the 16-bit external asynchronous SRAM, acting as the
// responder on the SRAM_* pins. Writes land in an internal array with
// per-byte-lane enables; reads return data on SRAM_DQ after READ_LAT clocks
// (0 = combinational path from address to bus).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   sram        control/address bundle (slave side)
//   SRAM_DQ     bidirectional data bus, high-Z unless this block is reading
//   rd_count    read cycles accepted, saturating
//   wr_count    write cycles accepted, saturating
//   raw_hazard  sticky: a write hit the address of a read still in flight
module sram_device_model #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  sram_device_model_if.slave sram,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   wr_count,
  output logic               raw_hazard
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic              is_read;
  logic              is_write;
  logic              bus_read;
  logic              drive_en;
  logic              head_valid;
  logic [15:0]       head_data;
  logic              hit;

  // Upper address bits beyond ADDR_W are dropped, so those words alias.
  assign addr     = sram.SRAM_ADDR[ADDR_W-1:0];
  assign is_write = !sram.SRAM_CE_N && !sram.SRAM_WE_N;
  // A read cycle is counted and queued whether or not OE_N is asserted.
  assign is_read  = !sram.SRAM_CE_N && sram.SRAM_WE_N;
  // The bus may only be driven while the initiator is in a read phase;
  // checking WE_N here releases the bus in the very cycle a write begins.
  assign bus_read = !sram.SRAM_CE_N && sram.SRAM_WE_N && !sram.SRAM_OE_N;

  generate
    if (ADDR_W < 18) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^sram.SRAM_ADDR[17:ADDR_W];
    end
  endgenerate

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (is_write) begin
      if (!sram.SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
      if (!sram.SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb
      assign head_valid = 1'b1;
      assign head_data  = mem[addr];
      assign hit        = 1'b0;
    end else begin : g_pipe
      logic [READ_LAT-1:0] pv;
      logic [ADDR_W-1:0]   pa [READ_LAT];
      logic [15:0]         pd [READ_LAT];

      // Stage 0 loads every clock; idle/write cycles enter as valid=0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
        end else begin
          for (int i = READ_LAT - 1; i > 0; i--) pv[i] <= pv[i-1];
          pv[0] <= is_read;
        end
      end

      // Data is captured at sampling time, so later writes to the same
      // word never alter a read already in flight.
      always_ff @(posedge clk) begin
        for (int i = READ_LAT - 1; i > 0; i--) begin
          pa[i] <= pa[i-1];
          pd[i] <= pd[i-1];
        end
        pa[0] <= addr;
        pd[0] <= mem[addr];
      end

      always_comb begin
        hit = 1'b0;
        for (int i = 0; i < READ_LAT; i++) begin
          if (pv[i] && (pa[i] == addr)) hit = 1'b1;
        end
      end

      assign head_valid = pv[READ_LAT-1];
      assign head_data  = pd[READ_LAT-1];
    end
  endgenerate

  // rst gates the drivers directly so the bus floats the instant reset rises.
  assign drive_en = head_valid && bus_read && !rst;

  // Lane enables are looked at when driving, not when the read was sampled.
  assign SRAM_DQ[7:0]  = (drive_en && !sram.SRAM_LB_N) ? head_data[7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = (drive_en && !sram.SRAM_UB_N) ? head_data[15:8] : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count   <= '0;
      wr_count   <= '0;
      raw_hazard <= 1'b0;
    end else begin
      if (is_read && (rd_count != CNT_MAX))  rd_count <= rd_count + CNT_W'(1);
      if (is_write && (wr_count != CNT_MAX)) wr_count <= wr_count + CNT_W'(1);
      if (is_write && hit) raw_hazard <= 1'b1;
    end
  end
endmodule
